seq_101101_tx: RTL

SEQ_101101_TX -- requirements
Module: seq_101101_tx

---
 rtl/seq_pkg.sv | 12 +
 rtl/seq_101101_tx_if.sv | 15 +
 rtl/seq_bit_ctr.sv | 24 ++
 rtl/seq_101101_tx.sv | 137 +++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared pattern defaults and FSM state type for the 101101 transmitter and detector.
// Contents: SEQ_PAT_W, SEQ_PATTERN, seq_state_t.
// Macro SEQ_TX_GAP_EN adds the GAP state to seq_state_t.
package seq_pkg;
    localparam int SEQ_PAT_W = 6;
    localparam logic [SEQ_PAT_W-1:0] SEQ_PATTERN = 6'b101101;
`ifdef SEQ_TX_GAP_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP, ST_FIN} seq_state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_FIN} seq_state_t;
`endif
endpackage

// File: rtl/seq_101101_tx_if.sv
// seq_101101_tx_if: burst request and serial output bundle of the pattern transmitter.
// Signals: start, burst_len[3:0], ready (toward the transmitter);
// out, out_valid, busy, done (from the transmitter).
// master = requester/sink side, slave = transmitter side.
interface seq_101101_tx_if;
    logic       start;
    logic [3:0] burst_len;
    logic       ready;
    logic       out;
    logic       out_valid;
    logic       busy;
    logic       done;
    modport master (output start, burst_len, ready, input out, out_valid, busy, done);
    modport slave (input start, burst_len, ready, output out, out_valid, busy, done);
endinterface

// File: rtl/seq_bit_ctr.sv
// seq_bit_ctr: loadable down-counter with zero flag; load wins over decrement.
// Ports: clk, rst (sync, active-high, loads RST_VAL), i_load, i_load_val, i_dec,
// o_cnt, o_zero.
module seq_bit_ctr #(
    parameter int           W       = 4,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst) r_cnt <= RST_VAL;
        else if (i_load) r_cnt <= i_load_val;
        else if (i_dec) r_cnt <= r_cnt - 1'b1;
    end
    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/seq_101101_tx.sv
// seq_101101_tx: sends PATTERN MSB first, burst_len times per start, with ready backpressure.
// Ports: clk, rst (sync, active-high), bus (seq_101101_tx_if.slave:
// start, burst_len, ready in; out, out_valid, busy, done out).
// Macro SEQ_TX_GAP_EN: insert GAP_CYCLES idle cycles between repetitions.
module seq_101101_tx
    import seq_pkg::*;
#(
    parameter int               PAT_W      = SEQ_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN    = SEQ_PATTERN,
    parameter int               GAP_CYCLES = 2
) (
    input logic                clk,
    input logic                rst,
    seq_101101_tx_if.slave     bus
);
    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

    if (GAP_CYCLES < 1) begin : g_gap_chk
        $error("GAP_CYCLES must be at least 1");
    end

    seq_state_t       r_state;
    logic             r_out;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;
    logic [IDX_W-1:0] w_idx;
    logic             w_idx_zero;
    logic [3:0]       w_rep;
    logic             w_rep_zero;
    logic             w_go;
    logic             w_hs;
    logic             w_wrap;

    assign w_go   = (r_state == ST_IDLE) && bus.start;
    assign w_hs   = (r_state == ST_SHIFT) && bus.ready;
    // Last bit of a repetition accepted while further repetitions remain.
    assign w_wrap = w_hs && w_idx_zero && !w_rep_zero;

    seq_bit_ctr #(.W(IDX_W), .RST_VAL(IDX_TOP)) u_idx (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_go || (w_hs && w_idx_zero)),
        .i_load_val(IDX_TOP),
        .i_dec     (w_hs && !w_idx_zero),
        .o_cnt     (w_idx),
        .o_zero    (w_idx_zero)
    );

    // Holds repetitions still to send after the current one, so zero marks the final pass.
    seq_bit_ctr #(.W(4), .RST_VAL(4'd0)) u_rep (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_go && (bus.burst_len != 4'd0)),
        .i_load_val(bus.burst_len - 4'd1),
        .i_dec     (w_wrap),
        .o_cnt     (w_rep),
        .o_zero    (w_rep_zero)
    );

`ifdef SEQ_TX_GAP_EN
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    logic [GAP_W-1:0] w_gap;
    logic             w_gap_zero;

    seq_bit_ctr #(.W(GAP_W), .RST_VAL('0)) u_gap (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_wrap),
        .i_load_val(GAP_W'(GAP_CYCLES - 1)),
        .i_dec     ((r_state == ST_GAP) && !w_gap_zero),
        .o_cnt     (w_gap),
        .o_zero    (w_gap_zero)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_out   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (bus.start) begin
                    r_busy <= 1'b1;
                    if (bus.burst_len != 4'd0) begin
                        r_state <= ST_SHIFT;
                        r_out   <= PATTERN[IDX_TOP];
                        r_valid <= 1'b1;
                    end else begin
                        r_state <= ST_FIN;
                        r_done  <= 1'b1;
                    end
                end
                ST_SHIFT: if (bus.ready) begin
                    if (!w_idx_zero) begin
                        r_out <= PATTERN[w_idx - 1'b1];
                    end else if (!w_rep_zero) begin
`ifdef SEQ_TX_GAP_EN
                        r_state <= ST_GAP;
                        r_out   <= 1'b0;
                        r_valid <= 1'b0;
`else
                        r_out <= PATTERN[IDX_TOP];
`endif
                    end else begin
                        r_state <= ST_FIN;
                        r_out   <= 1'b0;
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
`ifdef SEQ_TX_GAP_EN
                ST_GAP: if (w_gap_zero) begin
                    r_state <= ST_SHIFT;
                    r_out   <= PATTERN[IDX_TOP];
                    r_valid <= 1'b1;
                end
`endif
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule
